// File: rtl/seg_scan_mux.sv
`default_nettype none
// ---- seg_scan_mux : 4-digit 7-segment scan controller, frame-snapshot + LZ blanking -- rev 1.0 ----
module seg_scan_mux #(
    parameter int CLK_DIV = 50000,
    parameter int GUARD   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp,
    input  logic [3:0]  en,
    input  logic        lz,
    output logic [3:0]  an,
    output logic [3:0]  n,
    output logic        dp_n
);
    localparam int            CW     = $clog2(CLK_DIV);
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic          tick;
    logic          snap;
    logic          in_guard;

    logic [15:0]   bcd_s;
    logic [3:0]    dp_s;
    logic [3:0]    en_s;
    logic          lz_s;
    logic [15:0]   bcd_nx;
    logic [3:0]    dp_nx;
    logic [3:0]    en_nx;
    logic          lz_nx;

    logic          d3z;
    logic          d2z;
    logic          d1z;
    logic [3:0]    blank;
    logic [3:0]    vis;
    logic [3:0]    an_next;
    logic [3:0]    n_next;
    logic          dp_n_next;

    assign tick     = (cnt == C_LAST);
    assign snap     = tick && (idx == 2'd3);
    assign cnt_next = tick ? '0 : cnt + 1'b1;
    assign idx_next = tick ? idx + 2'd1 : idx;

    // Outputs are registered from post-edge state, so the snapshot is visible the cycle it is taken.
    assign bcd_nx = snap ? bcd : bcd_s;
    assign dp_nx  = snap ? dp  : dp_s;
    assign en_nx  = snap ? en  : en_s;
    assign lz_nx  = snap ? lz  : lz_s;

    generate
        if (GUARD > 0) begin : g_guard
            localparam logic [CW-1:0] C_GUARD = CW'(GUARD);
            assign in_guard = (cnt_next < C_GUARD);
        end else begin : g_no_guard
            assign in_guard = 1'b0;
        end
    endgenerate

    assign d3z   = (bcd_nx[15:12] == 4'd0);
    assign d2z   = (bcd_nx[11:8]  == 4'd0);
    assign d1z   = (bcd_nx[7:4]   == 4'd0);
    assign blank = {lz_nx & d3z, lz_nx & d3z & d2z, lz_nx & d3z & d2z & d1z, 1'b0};
    assign vis   = en_nx & ~blank;

    assign an_next   = (in_guard || !vis[idx_next]) ? 4'hF : ~(4'b0001 << idx_next);
    assign n_next    = bcd_nx[{idx_next, 2'b00} +: 4];
    assign dp_n_next = ~(dp_nx[idx_next] & vis[idx_next]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= 2'd0;
            bcd_s <= 16'h0000;
            dp_s  <= 4'h0;
            en_s  <= 4'h0;
            lz_s  <= 1'b0;
            an    <= 4'hF;
            n     <= 4'h0;
            dp_n  <= 1'b1;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            bcd_s <= bcd_nx;
            dp_s  <= dp_nx;
            en_s  <= en_nx;
            lz_s  <= lz_nx;
            an    <= an_next;
            n     <= n_next;
            dp_n  <= dp_n_next;
        end
    end
endmodule
`default_nettype wire
